regfile_wr_decode: RTL and testbench
====================================

Name: regfile_wr_decode

Overview:
- Write side of the integer register file: 32 x 64-bit storage, a 5:32 write-enable decoder, and two read ports.
- Takes the writeback destination index, data and enable, and steers the data into exactly one register on the rising clock edge.
- Sits between the writeback stage and the decode-stage read ports; the read ports are the consumers of the write path.
- X31 is hardwired to zero (XZR).

Parameters:
- DATA_W, 64, width of each register and of the data ports.
- ADDR_W, 5, width of each register index.
- NUM_REGS, 32, register count; must equal 2**ADDR_W.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- reg_write  in  1  write enable from writeback.
- write_reg  in  ADDR_W  destination register index.
- write_data  in  DATA_W  value to store.
- read_reg1  in  ADDR_W  read port A index.
- read_reg2  in  ADDR_W  read port B index.
- read_data1  out  DATA_W  port A data (combinational).
- read_data2  out  DATA_W  port B data (combinational).
- wr_ack  out  1  registered pulse: the previous cycle's write committed to a real register.

Behaviour:
- Reset is synchronous and active-high: when reset is 1 at a rising clk edge, all 32 registers clear to 0 and wr_ack clears to 0. Reset has priority over any write presented in the same cycle.
- Write decode: wr_en[i] = reg_write & (write_reg == i) & (i != 31). At most one wr_en bit is ever high.
- Write commit: on a rising edge with reset=0 and wr_en[i]=1, regs[i] <= write_data. All other registers hold their value.
- X31:
  - Writes to index 31 are discarded; no storage is updated and wr_ack stays 0.
  - read_data1/2 return 0 whenever their index is 31, regardless of stored content.
- wr_ack: next value = reg_write & (write_reg != 31) & ~reset. It is a one-cycle pulse per committed write; back-to-back writes hold it high continuously.
- Read ports:
  - Pure combinational 32:1 selection with zero latency.
  - Without bypass, a read of index k in the same cycle as a write to k returns the old value. The new value is visible from the cycle after the edge.
- Simultaneous events:
  - Both read ports may address the same register, and may address the register being written; both ports see identical data.
  - Write enable with an X/unknown write_reg is illegal input; the bench must never drive it.
- Reset mid-operation: if reset asserts in a cycle where reg_write=1, that write is lost and all registers read 0 after the edge.
- Widths: no arithmetic; all data paths are exactly DATA_W bits with no extension or truncation.

Optional Feature:
- Macro: REGFILE_WB_BYPASS_EN.
- Defined:
  - Each read port compares its index to write_reg.
  - If reg_write=1, the indices match, the index is not 31, and reset=0, the port returns write_data combinationally in the same cycle (write-before-read).
  - This removes the writeback-to-decode hazard.
- Undefined: no comparators are built; reads return the stored value as described above.
- The bypass never overrides the X31 read-as-zero rule.

Decomposition:
- Package regfile_pkg holds:
  - DATA_W, ADDR_W, NUM_REGS.
  - localparam ZERO_REG = 5'd31.
  - typedef logic [DATA_W-1:0] word_t.
  - typedef logic [ADDR_W-1:0] reg_idx_t.
- Sub-module decoder5_32:
  - Inputs: en and a 5-bit index. Output: a 32-bit one-hot enable vector.
  - Instantiated once for the write port; reusable by other blocks.
- Read selection reuses the existing 2:1 mux cells arranged as a 32:1 tree.

Test Plan:
- Reset: assert reset 1 cycle after random writes -> every index 0..31 reads 64'h0 on both ports; wr_ack = 0.
- Basic write: reg_write=1, write_reg=5, write_data=64'hDEAD_BEEF_0123_4567 for one edge -> read_reg1=5 returns that value the next cycle; wr_ack=1 for exactly one cycle; all other registers still read 0.
- X31 discard: write 64'hFFFF_FFFF_FFFF_FFFF to index 31 -> read_data1 of index 31 = 0; wr_ack stays 0; no other register changes.
- Same-cycle read/write on index 7 (old value 64'h1, new value 64'h2):
  - Without REGFILE_WB_BYPASS_EN: read_data1 = 64'h1 during the write cycle, 64'h2 after the edge.
  - With REGFILE_WB_BYPASS_EN: read_data1 = 64'h2 in the write cycle itself.
- Reset priority: reset=1 together with reg_write=1, write_reg=3, write_data=64'hAA -> reg3 reads 0 after the edge; wr_ack = 0.
- Sweep: write value i*64'h0101 to each index 0..30 on back-to-back cycles -> wr_ack stays high for 31 consecutive cycles; a readback of all indices on both ports matches, with index 31 reading 0.

Source files
------------

// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
// Module   : regfile_pkg
// Purpose  : Shared widths, the zero-register index and the word/index types
//            used by the integer register file write path.
// Contents : DATA_W, ADDR_W, NUM_REGS, ZERO_REG, word_t, reg_idx_t
// Options  : REGFILE_WB_BYPASS_EN (consumed by regfile_wr_decode)
// Revision : 1.0 - initial release
// ============================================================================
package regfile_pkg;

  localparam int DATA_W   = 64;
  localparam int ADDR_W   = 5;
  localparam int NUM_REGS = 32;   // must equal 2**ADDR_W

  localparam logic [ADDR_W-1:0] ZERO_REG = 5'd31;

  typedef logic [DATA_W-1:0] word_t;
  typedef logic [ADDR_W-1:0] reg_idx_t;

endpackage : regfile_pkg
`default_nettype wire

// File: rtl/regfile_wr_decode_decoder5_32.sv
`default_nettype none
// ============================================================================
// Module   : decoder5_32
// Purpose  : 5:32 one-hot decoder with enable. With en low the output is all
//            zeros, so at most one bit is ever set.
// Ports    : i_en     - decode enable
//            i_idx    - 5-bit index
//            o_onehot - 32-bit one-hot enable vector
// Revision : 1.0 - initial release
// ============================================================================
module decoder5_32 (
  input  logic        i_en,
  input  logic [4:0]  i_idx,
  output logic [31:0] o_onehot
);

  for (genvar g = 0; g < 32; g++) begin : g_dec
    assign o_onehot[g] = i_en & (i_idx == 5'(g));
  end

endmodule : decoder5_32
`default_nettype wire

// File: rtl/regfile_wr_decode.sv
`default_nettype none
// ============================================================================
// Module   : regfile_wr_decode
// Purpose  : Integer register file, 32 x 64-bit. One decoded write port from
//            writeback and two zero-latency combinational read ports. Index 31
//            is XZR: writes to it are discarded and it always reads as zero.
// Ports    : clk        - system clock, rising edge
//            reset      - synchronous active-high reset
//            reg_write  - write enable
//            write_reg  - write destination index
//            write_data - write data
//            read_reg1  - read port A index
//            read_reg2  - read port B index
//            read_data1 - read port A data (combinational)
//            read_data2 - read port B data (combinational)
//            wr_ack     - registered pulse, previous cycle's write committed
// Options  : REGFILE_WB_BYPASS_EN - forward write_data to a read port that
//            addresses the register being written in the same cycle.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_wr_decode
  import regfile_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              reg_write,
  input  logic [ADDR_W-1:0] write_reg,
  input  logic [DATA_W-1:0] write_data,
  input  logic [ADDR_W-1:0] read_reg1,
  input  logic [ADDR_W-1:0] read_reg2,
  output logic [DATA_W-1:0] read_data1,
  output logic [DATA_W-1:0] read_data2,
  output logic              wr_ack
);

  word_t               r_regs [NUM_REGS];
  logic                r_wr_ack;
  logic                w_wr_valid;
  logic [NUM_REGS-1:0] w_wr_en;
  word_t               w_sel1;
  word_t               w_sel2;

  // Masking XZR at the decoder input keeps the one-hot vector clear of bit 31.
  assign w_wr_valid = reg_write & (write_reg != ZERO_REG);

  decoder5_32 u_wr_dec (
    .i_en     (w_wr_valid),
    .i_idx    (write_reg),
    .o_onehot (w_wr_en)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
      r_wr_ack <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (w_wr_en[i]) r_regs[i] <= write_data;
      end
      r_wr_ack <= w_wr_valid;
    end
  end

  assign wr_ack = r_wr_ack;

  // 32:1 selection as a tree of 2:1 muxes. Each level halves the candidate
  // set in place, steered by one index bit, LSB first.
  function automatic word_t mux_tree(input word_t regs [NUM_REGS],
                                     input reg_idx_t idx);
    word_t v [NUM_REGS];
    for (int i = 0; i < NUM_REGS; i++) v[i] = regs[i];
    for (int l = 0; l < ADDR_W; l++) begin
      for (int k = 0; k < (NUM_REGS >> (l + 1)); k++) begin
        v[k] = idx[l] ? v[2*k+1] : v[2*k];
      end
    end
    return v[0];
  endfunction

  assign w_sel1 = mux_tree(r_regs, read_reg1);
  assign w_sel2 = mux_tree(r_regs, read_reg2);

`ifdef REGFILE_WB_BYPASS_EN
  // w_wr_valid already excludes XZR; the read-side XZR check below still
  // takes precedence.
  logic w_byp1;
  logic w_byp2;
  assign w_byp1 = w_wr_valid & ~reset & (read_reg1 == write_reg);
  assign w_byp2 = w_wr_valid & ~reset & (read_reg2 == write_reg);

  assign read_data1 = (read_reg1 == ZERO_REG) ? '0 :
                      w_byp1                  ? write_data : w_sel1;
  assign read_data2 = (read_reg2 == ZERO_REG) ? '0 :
                      w_byp2                  ? write_data : w_sel2;
`else
  assign read_data1 = (read_reg1 == ZERO_REG) ? '0 : w_sel1;
  assign read_data2 = (read_reg2 == ZERO_REG) ? '0 : w_sel2;
`endif

endmodule : regfile_wr_decode
`default_nettype wire

// File: tb/tb_regfile_wr_decode.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_wr_decode
// Purpose  : Self-checking bench for regfile_wr_decode. Expected read data and
//            wr_ack are computed by a reference model and queued when the
//            stimulus is driven, then popped and compared against the DUT.
// Options  : REGFILE_WB_BYPASS_EN selects same-cycle forwarding expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_wr_decode;

  logic        clk = 1'b0;
  logic        reset;
  logic        reg_write;
  logic [4:0]  write_reg;
  logic [63:0] write_data;
  logic [4:0]  read_reg1;
  logic [4:0]  read_reg2;
  logic [63:0] read_data1;
  logic [63:0] read_data2;
  logic        wr_ack;

  regfile_wr_decode dut (
    .clk        (clk),
    .reset      (reset),
    .reg_write  (reg_write),
    .write_reg  (write_reg),
    .write_data (write_data),
    .read_reg1  (read_reg1),
    .read_reg2  (read_reg2),
    .read_data1 (read_data1),
    .read_data2 (read_data2),
    .wr_ack     (wr_ack)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  logic [63:0] model [32];
  logic [63:0] q_rd1 [$];
  logic [63:0] q_rd2 [$];
  logic        q_ack [$];

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] exp_rd(input logic [4:0] idx);
    if (idx == 5'd31) return 64'h0;
`ifdef REGFILE_WB_BYPASS_EN
    if (reg_write && !reset && write_reg == idx) return write_data;
`endif
    return model[idx];
  endfunction

  // One clock of stimulus: reads are checked during the cycle, wr_ack and
  // the model update after the edge.
  task automatic step(input logic rst, input logic we, input logic [4:0] wa,
                      input logic [63:0] wd, input logic [4:0] ra1,
                      input logic [4:0] ra2);
    logic exp_ack;
    @(negedge clk);
    reset = rst; reg_write = we; write_reg = wa; write_data = wd;
    read_reg1 = ra1; read_reg2 = ra2;
    q_rd1.push_back(exp_rd(ra1));
    q_rd2.push_back(exp_rd(ra2));
    #1;
    chk($sformatf("rd1[%0d]", ra1), read_data1, q_rd1.pop_front());
    chk($sformatf("rd2[%0d]", ra2), read_data2, q_rd2.pop_front());
    if (rst) begin
      for (int i = 0; i < 32; i++) model[i] = 64'h0;
      exp_ack = 1'b0;
    end else begin
      exp_ack = we && (wa != 5'd31);
      if (exp_ack) model[wa] = wd;
    end
    q_ack.push_back(exp_ack);
    @(posedge clk);
    #1;
    chk("wr_ack", {63'h0, wr_ack}, {63'h0, q_ack.pop_front()});
  endtask

  task automatic read_all();
    for (int i = 0; i < 32; i++) step(1'b0, 1'b0, 5'd0, 64'h0, 5'(i), 5'(31 - i));
  endtask

  initial begin
    reset = 1'b1; reg_write = 1'b0; write_reg = '0; write_data = '0;
    read_reg1 = '0; read_reg2 = '0;
    for (int i = 0; i < 32; i++) model[i] = 64'h0;
    repeat (2) @(posedge clk);

    // Reset state
    read_all();

    // Basic write to index 5, then ack drops and others stay zero
    step(1'b0, 1'b1, 5'd5, 64'hDEAD_BEEF_0123_4567, 5'd5, 5'd4);
    step(1'b0, 1'b0, 5'd0, 64'h0, 5'd5, 5'd5);
    read_all();

    // XZR write is discarded
    step(1'b0, 1'b1, 5'd31, 64'hFFFF_FFFF_FFFF_FFFF, 5'd31, 5'd31);
    step(1'b0, 1'b0, 5'd0, 64'h0, 5'd31, 5'd5);

    // Same-cycle read/write on index 7
    step(1'b0, 1'b1, 5'd7, 64'h1, 5'd0, 5'd1);
    step(1'b0, 1'b1, 5'd7, 64'h2, 5'd7, 5'd7);
    step(1'b0, 1'b0, 5'd0, 64'h0, 5'd7, 5'd7);

    // Reset has priority over a simultaneous write
    step(1'b0, 1'b1, 5'd3, 64'h55, 5'd3, 5'd3);
    step(1'b1, 1'b1, 5'd3, 64'hAA, 5'd3, 5'd3);
    step(1'b0, 1'b0, 5'd0, 64'h0, 5'd3, 5'd7);

    // Random writes with random reads, then reset clears everything
    for (int i = 0; i < 40; i++)
      step(1'b0, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
           {$urandom, $urandom}, 5'($urandom_range(0, 31)),
           5'($urandom_range(0, 31)));
    step(1'b1, 1'b0, 5'd0, 64'h0, 5'd0, 5'd0);
    read_all();

    // Back-to-back sweep: wr_ack held high, then full readback
    for (int i = 0; i < 31; i++)
      step(1'b0, 1'b1, 5'(i), 64'(i) * 64'h0101, 5'(i), 5'((i + 1) % 32));
    read_all();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_regfile_wr_decode
`default_nettype wire
